// File: rtl/scr1_tb_ahb_dmem_split.sv
// AHB-Lite 1-master/2-slave dmem splitter with built-in default (ERROR) slave.
// Optional stall timeout with slave orphaning: define SCR1_TB_AHB_SPLIT_TIMEOUT_EN.
//   state  | meaning
//   D_IDLE | no default-slave data phase in progress
//   D_ERR1 | first ERROR cycle (hready=0, hresp=1)
//   D_ERR2 | second ERROR cycle (hready=1, hresp=1)
module scr1_tb_ahb_dmem_split #(
    parameter logic [31:0] S0_BASE        = 32'h0000_0000,
    parameter logic [31:0] S0_MASK        = 32'hFF00_0000,
    parameter logic [31:0] S1_BASE        = 32'hF000_0000,
    parameter logic [31:0] S1_MASK        = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  m_htrans,
    input  logic [31:0] m_haddr,
    input  logic        m_hwrite,
    input  logic [2:0]  m_hsize,
    input  logic [31:0] m_hwdata,
    output logic        m_hready,
    output logic [31:0] m_hrdata,
    output logic        m_hresp,
    output logic [31:0] s_haddr,
    output logic        s_hwrite,
    output logic [2:0]  s_hsize,
    output logic [31:0] s_hwdata,
    output logic [1:0]  s0_htrans,
    output logic [1:0]  s1_htrans,
    input  logic        s0_hready,
    input  logic        s1_hready,
    input  logic [31:0] s0_hrdata,
    input  logic [31:0] s1_hrdata,
    input  logic        s0_hresp,
`ifdef SCR1_TB_AHB_SPLIT_TIMEOUT_EN
    output logic        timeout_flag,
`endif
    input  logic        s1_hresp
);

    typedef enum logic [1:0] {SEL_NONE, SEL_S0, SEL_S1, SEL_DEF} sel_e;
    typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_e;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit stall counter");
    end

    sel_e       dph_sel_q, dph_sel_d, aph_sel;
    dstate_e    dstate_q, dstate_d;
    logic       dec_s0, dec_s1;
    logic [1:0] orphan_q;
    logic       timeout_hit;

    assign dec_s0 = (m_haddr & S0_MASK) == S0_BASE;
    assign dec_s1 = (m_haddr & S1_MASK) == S1_BASE;

    // An orphaned slave's address range falls through to the default slave.
    always_comb begin
        aph_sel = SEL_NONE;
        if (m_htrans[1]) begin
            if (dec_s0 && !orphan_q[0])
                aph_sel = SEL_S0;
            else if (!dec_s0 && dec_s1 && !orphan_q[1])
                aph_sel = SEL_S1;
            else
                aph_sel = SEL_DEF;
        end
    end

    assign s_haddr   = m_haddr;
    assign s_hwrite  = m_hwrite;
    assign s_hsize   = m_hsize;
    assign s_hwdata  = m_hwdata;
    assign s0_htrans = (m_hready && aph_sel == SEL_S0) ? m_htrans : 2'b00;
    assign s1_htrans = (m_hready && aph_sel == SEL_S1) ? m_htrans : 2'b00;

    always_comb begin
        m_hready = 1'b1;
        m_hresp  = 1'b0;
        m_hrdata = '0;
        case (dph_sel_q)
            SEL_S0: begin
                m_hready = s0_hready;
                m_hresp  = s0_hresp;
                m_hrdata = s0_hresp ? 32'h0 : s0_hrdata;
            end
            SEL_S1: begin
                m_hready = s1_hready;
                m_hresp  = s1_hresp;
                m_hrdata = s1_hresp ? 32'h0 : s1_hrdata;
            end
            SEL_DEF: begin
                m_hready = (dstate_q == D_ERR2);
                m_hresp  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        dph_sel_d = dph_sel_q;
        dstate_d  = dstate_q;
        if (m_hready)
            dph_sel_d = aph_sel;
        case (dstate_q)
            D_IDLE:  if (m_hready && aph_sel == SEL_DEF) dstate_d = D_ERR1;
            D_ERR1:  dstate_d = D_ERR2;
            D_ERR2:  dstate_d = (aph_sel == SEL_DEF) ? D_ERR1 : D_IDLE;
            default: dstate_d = D_IDLE;
        endcase
        // A timed-out slave's data phase is converted into a default-slave ERROR.
        if (timeout_hit) begin
            dph_sel_d = SEL_DEF;
            dstate_d  = D_ERR1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_sel_q <= SEL_NONE;
            dstate_q  <= D_IDLE;
        end else begin
            dph_sel_q <= dph_sel_d;
            dstate_q  <= dstate_d;
        end
    end

`ifdef SCR1_TB_AHB_SPLIT_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_flag_q, timeout_flag_d;
    logic [1:0]  orphan_d;
    logic        stall;

    assign stall       = (dph_sel_q == SEL_S0 && !s0_hready) ||
                         (dph_sel_q == SEL_S1 && !s1_hready);
    assign timeout_hit = stall && (stall_cnt_q == TIMEOUT_LAST);

    always_comb begin
        stall_cnt_d    = stall ? stall_cnt_q + 16'd1 : 16'd0;
        timeout_flag_d = timeout_flag_q | timeout_hit;
        orphan_d       = orphan_q;
        if (timeout_hit)
            stall_cnt_d = 16'd0;
        if (s0_hready) orphan_d[0] = 1'b0;
        if (s1_hready) orphan_d[1] = 1'b0;
        if (timeout_hit && dph_sel_q == SEL_S0) orphan_d[0] = 1'b1;
        if (timeout_hit && dph_sel_q == SEL_S1) orphan_d[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q    <= 16'd0;
            timeout_flag_q <= 1'b0;
            orphan_q       <= 2'b00;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            timeout_flag_q <= timeout_flag_d;
            orphan_q       <= orphan_d;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    assign timeout_hit = 1'b0;
    assign orphan_q    = 2'b00;
`endif

endmodule

// File: tb/tb_scr1_tb_ahb_dmem_split.sv
// Directed testbench for scr1_tb_ahb_dmem_split; the timeout scenario runs when
// SCR1_TB_AHB_SPLIT_TIMEOUT_EN is defined.
module tb_scr1_tb_ahb_dmem_split;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_htrans;
    logic [31:0] m_haddr;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic        m_hready;
    logic [31:0] m_hrdata;
    logic        m_hresp;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [31:0] s_hwdata;
    logic [1:0]  s0_htrans, s1_htrans;
    logic        s0_hready, s1_hready;
    logic [31:0] s0_hrdata, s1_hrdata;
    logic        s0_hresp, s1_hresp;
`ifdef SCR1_TB_AHB_SPLIT_TIMEOUT_EN
    logic        timeout_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

`ifdef SCR1_TB_AHB_SPLIT_TIMEOUT_EN
    scr1_tb_ahb_dmem_split #(.TIMEOUT_CYCLES(8)) dut (
`else
    scr1_tb_ahb_dmem_split dut (
`endif
        .clk(clk), .rst_n(rst_n),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hwdata(m_hwdata),
        .m_hready(m_hready), .m_hrdata(m_hrdata), .m_hresp(m_hresp),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hwdata(s_hwdata),
        .s0_htrans(s0_htrans), .s1_htrans(s1_htrans),
        .s0_hready(s0_hready), .s1_hready(s1_hready),
        .s0_hrdata(s0_hrdata), .s1_hrdata(s1_hrdata),
        .s0_hresp(s0_hresp),
`ifdef SCR1_TB_AHB_SPLIT_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .s1_hresp(s1_hresp)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr(input logic [1:0] tr, input logic [31:0] a, input logic w);
        m_htrans = tr;
        m_haddr  = a;
        m_hwrite = w;
        m_hsize  = 3'd2;
    endtask

    task automatic resp_chk(input string tag, input logic rdy, input logic rsp, input logic [31:0] rd);
        check_val({tag, "_hready"}, 32'(m_hready), 32'(rdy));
        check_val({tag, "_hresp"},  32'(m_hresp),  32'(rsp));
        check_val({tag, "_hrdata"}, m_hrdata, rd);
    endtask

    initial begin
        rst_n = 1'b0;
        addr(2'b00, 32'h0, 1'b0);
        m_hwdata  = '0;
        s0_hready = 1'b1; s1_hready = 1'b1;
        s0_hrdata = 32'h1111_1111; s1_hrdata = 32'h2222_2222;
        s0_hresp  = 1'b0; s1_hresp  = 1'b0;
        tick(); tick();
        @(negedge clk);
        resp_chk("rst", 1'b1, 1'b0, 32'h0);
        check_val("rst_s0_htrans", 32'(s0_htrans), 32'h0);
        check_val("rst_s1_htrans", 32'(s1_htrans), 32'h0);
        tick();
        rst_n = 1'b1;

        // 1: S0 read, zero waits
        addr(2'b10, 32'h0000_0100, 1'b0);
        @(negedge clk);
        check_val("t1_s0_htrans", 32'(s0_htrans), 32'h2);
        check_val("t1_s1_htrans", 32'(s1_htrans), 32'h0);
        check_val("t1_s_haddr", s_haddr, 32'h0000_0100);
        tick();
        addr(2'b00, 32'h0, 1'b0);
        s0_hrdata = 32'hDEAD_BEEF;
        @(negedge clk);
        resp_chk("t1_data", 1'b1, 1'b0, 32'hDEAD_BEEF);
        check_val("t1_s1_idle", 32'(s1_htrans), 32'h0);
        tick();

        // 2: S1 write with 3 wait states
        addr(2'b10, 32'hF000_0004, 1'b1);
        @(negedge clk);
        check_val("t2_s1_htrans", 32'(s1_htrans), 32'h2);
        check_val("t2_s0_htrans", 32'(s0_htrans), 32'h0);
        check_val("t2_s_hwrite", 32'(s_hwrite), 32'h1);
        tick();
        addr(2'b00, 32'h0, 1'b0);
        m_hwdata  = 32'h1234_5678;
        s1_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t2_wait_hready", 32'(m_hready), 32'h0);
            check_val("t2_wait_hwdata", s_hwdata, 32'h1234_5678);
            tick();
        end
        s1_hready = 1'b1;
        @(negedge clk);
        check_val("t2_done_hready", 32'(m_hready), 32'h1);
        check_val("t2_done_hwdata", s_hwdata, 32'h1234_5678);
        check_val("t2_done_s0_htrans", 32'(s0_htrans), 32'h0);
        tick();

        // 3: unmapped read, then back-to-back DEF to DEF
        addr(2'b10, 32'h8000_0000, 1'b0);
        @(negedge clk);
        check_val("t3_s0_htrans", 32'(s0_htrans), 32'h0);
        check_val("t3_s1_htrans", 32'(s1_htrans), 32'h0);
        tick();
        addr(2'b00, 32'h0, 1'b0);
        @(negedge clk);
        resp_chk("t3_err1", 1'b0, 1'b1, 32'h0);
        tick();
        addr(2'b10, 32'h8000_0010, 1'b0);
        @(negedge clk);
        resp_chk("t3_err2", 1'b1, 1'b1, 32'h0);
        tick();
        addr(2'b00, 32'h0, 1'b0);
        @(negedge clk);
        resp_chk("t3_b2b_err1", 1'b0, 1'b1, 32'h0);
        tick();
        @(negedge clk);
        resp_chk("t3_b2b_err2", 1'b1, 1'b1, 32'h0);
        tick();
        @(negedge clk);
        resp_chk("t3_idle", 1'b1, 1'b0, 32'h0);

        // 4: S0 (2 stalls), S1, S0 pipelined
        addr(2'b10, 32'h0000_0200, 1'b0);
        tick();
        addr(2'b10, 32'hF000_0010, 1'b0);
        s0_hready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("t4_stall_hready", 32'(m_hready), 32'h0);
            check_val("t4_stall_s1_htrans", 32'(s1_htrans), 32'h0);
            tick();
        end
        s0_hready = 1'b1;
        s0_hrdata = 32'h0000_00A1;
        @(negedge clk);
        resp_chk("t4_d0", 1'b1, 1'b0, 32'h0000_00A1);
        check_val("t4_s1_htrans", 32'(s1_htrans), 32'h2);
        tick();
        addr(2'b10, 32'h0000_0300, 1'b0);
        s1_hrdata = 32'h0000_00B2;
        @(negedge clk);
        resp_chk("t4_d1", 1'b1, 1'b0, 32'h0000_00B2);
        check_val("t4_s0_htrans", 32'(s0_htrans), 32'h2);
        tick();
        addr(2'b00, 32'h0, 1'b0);
        s0_hrdata = 32'h0000_00C3;
        @(negedge clk);
        resp_chk("t4_d2", 1'b1, 1'b0, 32'h0000_00C3);
        tick();

        // slave ERROR forwarded, read data masked
        addr(2'b10, 32'h0000_0040, 1'b0);
        tick();
        addr(2'b00, 32'h0, 1'b0);
        s0_hready = 1'b0; s0_hresp = 1'b1; s0_hrdata = 32'hFFFF_FFFF;
        @(negedge clk);
        resp_chk("se_c1", 1'b0, 1'b1, 32'h0);
        tick();
        s0_hready = 1'b1;
        @(negedge clk);
        resp_chk("se_c2", 1'b1, 1'b1, 32'h0);
        tick();
        s0_hresp = 1'b0;

        // 5: reset during an S1 wait state
        addr(2'b10, 32'hF000_0020, 1'b0);
        tick();
        addr(2'b00, 32'h0, 1'b0);
        s1_hready = 1'b0;
        s1_hrdata = 32'h3333_3333;
        #1;
        check_val("t5_wait_hready", 32'(m_hready), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        resp_chk("t5_rst", 1'b1, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        resp_chk("t5_post_rst", 1'b1, 1'b0, 32'h0);
        tick();
        s1_hready = 1'b1;
        addr(2'b10, 32'h0000_0400, 1'b0);
        @(negedge clk);
        check_val("t5_s0_htrans", 32'(s0_htrans), 32'h2);
        tick();
        addr(2'b00, 32'h0, 1'b0);
        s0_hrdata = 32'h0000_55AA;
        @(negedge clk);
        resp_chk("t5_s0_data", 1'b1, 1'b0, 32'h0000_55AA);
        tick();

`ifdef SCR1_TB_AHB_SPLIT_TIMEOUT_EN
        // 6: S0 hangs, timeout after 8 stall cycles
        begin
            int n_stall;
            check_val("t6_flag_clear", 32'(timeout_flag), 32'h0);
            addr(2'b10, 32'h0000_0500, 1'b0);
            tick();
            addr(2'b00, 32'h0, 1'b0);
            s0_hready = 1'b0;
            n_stall = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m_hready === 1'b0 && m_hresp === 1'b0) begin
                    n_stall++;
                    tick();
                end else begin
                    break;
                end
            end
            check_val("t6_stall_cycles", 32'(n_stall), 32'd8);
            resp_chk("t6_err1", 1'b0, 1'b1, 32'h0);
            check_val("t6_flag", 32'(timeout_flag), 32'h1);
            tick();
            addr(2'b10, 32'h0000_0600, 1'b0);
            @(negedge clk);
            resp_chk("t6_err2", 1'b1, 1'b1, 32'h0);
            check_val("t6_orphan_s0_htrans", 32'(s0_htrans), 32'h0);
            tick();
            addr(2'b00, 32'h0, 1'b0);
            @(negedge clk);
            resp_chk("t6_orphan_err1", 1'b0, 1'b1, 32'h0);
            tick();
            @(negedge clk);
            resp_chk("t6_orphan_err2", 1'b1, 1'b1, 32'h0);
            tick();
            s0_hready = 1'b1;
            tick();
            addr(2'b10, 32'h0000_0700, 1'b0);
            @(negedge clk);
            check_val("t6_recover_s0_htrans", 32'(s0_htrans), 32'h2);
            check_val("t6_flag_sticky", 32'(timeout_flag), 32'h1);
            tick();
            addr(2'b00, 32'h0, 1'b0);
            s0_hrdata = 32'h0000_0777;
            @(negedge clk);
            resp_chk("t6_recover_data", 1'b1, 1'b0, 32'h0000_0777);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
